// File: rtl/dvp_axis_pkg.sv
// Shared types for the DVP-to-AXIS pixel packer: FSM states, AXIS sideband and word-width helper.
package dvp_axis_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_RESYNC = 2'd2
   } state_e;

   typedef struct packed {
      logic tuser;
      logic tlast;
   } side_t;

   localparam int unsigned SIDE_W = $bits(side_t);

   function automatic int unsigned pixel_width(input int unsigned dw, input int unsigned bpp);
      return dw * bpp;
   endfunction

   localparam int unsigned DVP_PIX_W = pixel_width(8, 2);

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; full is judged before any same-cycle pop.
module axis_sync_fifo #(
   parameter int unsigned WIDTH_P = 18,
   parameter int unsigned DEPTH_P = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [WIDTH_P-1:0] push_data,
   output logic               full_c,
   input  logic               pop,
   output logic [WIDTH_P-1:0] pop_data_c,
   output logic               empty_c
);

   localparam int unsigned AW = $clog2(DEPTH_P);

   logic [WIDTH_P-1:0] mem [DEPTH_P];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;
   logic               wr_en;
   logic               rd_en;

   assign full_c     = (count == (AW+1)'(DEPTH_P));
   assign empty_c    = (count == '0);
   assign wr_en      = push & ~full_c;
   assign rd_en      = pop & ~empty_c;
   // Head word shows zero while empty so nothing stale leaks onto the bus.
   assign pop_data_c = empty_c ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         unique case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dvp_axis_pack.sv
// Packs multi-sample DVP pixels into AXIS beats (tuser = SOF, tlast = EOL) through a FWFT FIFO.
// Define DVP_AXIS_PACK_BYTESWAP_EN to place the first sample of each pixel in the LS byte.
module dvp_axis_pack
   import dvp_axis_pkg::*;
#(
   parameter int unsigned DATA_WIDTH_P      = 8,
   parameter int unsigned BYTES_PER_PIXEL_P = 2,
   parameter int unsigned FIFO_DEPTH_P      = 16,
   parameter int unsigned LINE_CNT_W_P      = 12
) (
   input  logic                                          pclk_i,
   input  logic                                          rstn_i,
   input  logic                                          vsync_i,
   input  logic                                          hsync_i,
   input  logic [DATA_WIDTH_P-1:0]                       data_i,
   output logic [DATA_WIDTH_P*BYTES_PER_PIXEL_P-1:0]     tdata_o,
   output logic [DATA_WIDTH_P*BYTES_PER_PIXEL_P/8-1:0]   tkeep_o,
   output logic                                          tuser_o,
   output logic                                          tlast_o,
   output logic                                          tvalid_o,
   input  logic                                          tready_i,
   output logic                                          overflow_o,
   output logic [LINE_CNT_W_P-1:0]                       line_cnt_o
);

   localparam int unsigned PIX_W  = pixel_width(DATA_WIDTH_P, BYTES_PER_PIXEL_P);
   localparam int unsigned FIFO_W = PIX_W + SIDE_W;
   localparam int unsigned BCNT_W = (BYTES_PER_PIXEL_P > 1) ? $clog2(BYTES_PER_PIXEL_P) : 1;
   localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_PIXEL_P - 1);

   logic                    vs_q, vs_qq, hs_q, hs_qq;
   logic [DATA_WIDTH_P-1:0] d_q;
   state_e                  state;
   logic [BCNT_W-1:0]       byte_cnt;
   logic [PIX_W-1:0]        word_q;
   logic [PIX_W-1:0]        pend_word;
   logic                    pend_vld;
   logic                    pend_sof;
   logic                    sof;

   logic                    vs_rise_c, hs_fall_c, pix_done_c, line_end_c;
   logic                    push_c, ovf_c;
   logic [BCNT_W-1:0]       lane_c;
   logic [PIX_W-1:0]        word_nxt_c;
   side_t                   push_side_c;
   logic                    fifo_full_c, fifo_empty_c;
   logic [FIFO_W-1:0]       fifo_out_c;
   side_t                   out_side_c;

   assign vs_rise_c  = vs_q & ~vs_qq;
   assign hs_fall_c  = ~hs_q & hs_qq;
   assign pix_done_c = (state == ST_ACTIVE) && hs_q && !vs_rise_c && (byte_cnt == LAST_BYTE);
   assign line_end_c = (state == ST_ACTIVE) && hs_fall_c && !vs_rise_c && pend_vld;
   assign push_c     = (pix_done_c && pend_vld) || line_end_c;
   assign ovf_c      = push_c && fifo_full_c;

   // Byte lane for the current sample and the word with that sample merged in.
   always_comb begin
`ifdef DVP_AXIS_PACK_BYTESWAP_EN
      lane_c = byte_cnt;
`else
      lane_c = LAST_BYTE - byte_cnt;
`endif
      word_nxt_c = word_q;
      word_nxt_c[32'(lane_c)*DATA_WIDTH_P +: DATA_WIDTH_P] = d_q;
      push_side_c.tuser = pend_sof;
      push_side_c.tlast = line_end_c;
   end

   always_ff @(posedge pclk_i) begin
      if (!rstn_i) begin
         vs_q       <= 1'b0;
         vs_qq      <= 1'b0;
         hs_q       <= 1'b0;
         hs_qq      <= 1'b0;
         d_q        <= '0;
         state      <= ST_IDLE;
         byte_cnt   <= '0;
         word_q     <= '0;
         pend_word  <= '0;
         pend_vld   <= 1'b0;
         pend_sof   <= 1'b0;
         sof        <= 1'b0;
         overflow_o <= 1'b0;
         line_cnt_o <= '0;
      end else begin
         vs_q  <= vsync_i;
         vs_qq <= vs_q;
         hs_q  <= hsync_i;
         hs_qq <= hs_q;
         d_q   <= data_i;
         if (vs_rise_c) begin
            state      <= ST_ACTIVE;
            sof        <= 1'b1;
            byte_cnt   <= '0;
            pend_vld   <= 1'b0;
            line_cnt_o <= '0;
         end else begin
            unique case (state)
               ST_ACTIVE: begin
                  if (ovf_c) begin
                     overflow_o <= 1'b1;
                     state      <= ST_RESYNC;
                     pend_vld   <= 1'b0;
                     byte_cnt   <= '0;
                  end else if (hs_q) begin
                     if (byte_cnt == LAST_BYTE) begin
                        byte_cnt  <= '0;
                        pend_word <= word_nxt_c;
                        pend_sof  <= sof;
                        pend_vld  <= 1'b1;
                        sof       <= 1'b0;
                     end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                        word_q   <= word_nxt_c;
                     end
                  end else if (hs_fall_c) begin
                     byte_cnt <= '0;
                     if (pend_vld) begin
                        pend_vld   <= 1'b0;
                        line_cnt_o <= line_cnt_o + 1'b1;
                     end
                  end
               end
               default: byte_cnt <= '0;
            endcase
         end
      end
   end

   axis_sync_fifo #(
      .WIDTH_P (FIFO_W),
      .DEPTH_P (FIFO_DEPTH_P)
   ) u_fifo (
      .clk        (pclk_i),
      .rst_n      (rstn_i),
      .push       (push_c),
      .push_data  ({pend_word, push_side_c}),
      .full_c     (fifo_full_c),
      .pop        (tvalid_o & tready_i),
      .pop_data_c (fifo_out_c),
      .empty_c    (fifo_empty_c)
   );

   assign out_side_c = side_t'(fifo_out_c[SIDE_W-1:0]);
   assign tdata_o    = fifo_out_c[FIFO_W-1 -: PIX_W];
   assign tuser_o    = out_side_c.tuser;
   assign tlast_o    = out_side_c.tlast;
   assign tvalid_o   = ~fifo_empty_c;
   assign tkeep_o    = '1;

endmodule

// File: tb/tb_dvp_axis_pack.sv
// Randomized bench for dvp_axis_pack with a line/pixel-level reference model and beat scoreboard.
module tb_dvp_axis_pack;

   localparam int unsigned DW    = 8;
   localparam int unsigned BPP   = 2;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned LCW   = 12;
   localparam int unsigned PW    = DW * BPP;

   typedef struct {
      logic [63:0] data;
      bit          user;
      bit          last;
   } beat_t;

   logic              pclk_i = 1'b0;
   logic              rstn_i = 1'b0;
   logic              vsync_i = 1'b0;
   logic              hsync_i = 1'b0;
   logic [DW-1:0]     data_i = '0;
   logic [PW-1:0]     tdata_o;
   logic [PW/8-1:0]   tkeep_o;
   logic              tuser_o, tlast_o, tvalid_o;
   logic              tready_i = 1'b0;
   logic              overflow_o;
   logic [LCW-1:0]    line_cnt_o;

   int          n_chk = 0;
   int          n_fail = 0;
   int          beat_cnt = 0;
   int          ready_mode = 0;
   beat_t       exp_q[$];
   logic [DW-1:0] line_q[$];
   bit          model_active = 0;
   bit          model_sof = 0;
   int          model_lines = 0;

   dvp_axis_pack #(
      .DATA_WIDTH_P      (DW),
      .BYTES_PER_PIXEL_P (BPP),
      .FIFO_DEPTH_P      (DEPTH),
      .LINE_CNT_W_P      (LCW)
   ) dut (
      .pclk_i     (pclk_i),
      .rstn_i     (rstn_i),
      .vsync_i    (vsync_i),
      .hsync_i    (hsync_i),
      .data_i     (data_i),
      .tdata_o    (tdata_o),
      .tkeep_o    (tkeep_o),
      .tuser_o    (tuser_o),
      .tlast_o    (tlast_o),
      .tvalid_o   (tvalid_o),
      .tready_i   (tready_i),
      .overflow_o (overflow_o),
      .line_cnt_o (line_cnt_o)
   );

   always #5 pclk_i = ~pclk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk_i);
      #2;
   endtask

   always @(posedge pclk_i) begin
      #2;
      case (ready_mode)
         0:       tready_i = 1'b0;
         1:       tready_i = 1'b1;
         default: tready_i = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Scoreboard: every accepted beat must match the head of the expected queue.
   always @(negedge pclk_i) begin
      if (rstn_i && tvalid_o && tready_i) begin
         beat_cnt++;
         if (exp_q.size() == 0) begin
            chk("extra_beat", 64'(tdata_o), 64'hdead_beef);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("beat_data", 64'(tdata_o), e.data);
            chk("beat_tuser", 64'(tuser_o), 64'(e.user));
            chk("beat_tlast", 64'(tlast_o), 64'(e.last));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      rstn_i  = 1'b0;
      hsync_i = 1'b0;
      vsync_i = 1'b0;
      repeat (3) tick();
      exp_q.delete();
      model_active = 0;
      model_sof    = 0;
      model_lines  = 0;
   endtask

   task automatic send_vsync();
      vsync_i = 1'b1;
      repeat (3) tick();
      vsync_i = 1'b0;
      repeat (3) tick();
      model_active = 1;
      model_sof    = 1;
      model_lines  = 0;
   endtask

   // Drives one hsync-high line; bytes come from line_q if filled, else random.
   task automatic send_line(input int nbytes, input bit stalled);
      logic [DW-1:0] b[$];
      int npix;
      int nkeep;
      for (int i = 0; i < nbytes; i++) begin
         if (line_q.size() != 0) b.push_back(line_q.pop_front());
         else b.push_back(DW'($urandom));
      end
      line_q.delete();
      npix = nbytes / BPP;
      if (model_active) begin
         nkeep = npix;
         if (stalled && npix > int'(DEPTH)) nkeep = DEPTH;
         for (int p = 0; p < nkeep; p++) begin
            beat_t e;
            logic [63:0] w;
            w = '0;
            for (int k = 0; k < int'(BPP); k++) begin
`ifdef DVP_AXIS_PACK_BYTESWAP_EN
               w = w | (64'(b[p*BPP+k]) << (k*DW));
`else
               w = (w << DW) | 64'(b[p*BPP+k]);
`endif
            end
            e.data = w;
            e.user = model_sof;
            e.last = (p == npix - 1);
            model_sof = 0;
            exp_q.push_back(e);
         end
         if (nkeep < npix) model_active = 0;
         else if (npix > 0) model_lines = (model_lines + 1) % (1 << LCW);
      end
      hsync_i = 1'b1;
      for (int i = 0; i < nbytes; i++) begin
         data_i = b[i];
         tick();
      end
      hsync_i = 1'b0;
      data_i  = DW'($urandom);
      repeat (5) tick();
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
      repeat (3) tick();
      chk(tag, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int base;
      logic [PW-1:0] held;

      apply_reset();
      chk("rst_tvalid", 64'(tvalid_o), 64'd0);
      chk("rst_tuser", 64'(tuser_o), 64'd0);
      chk("rst_tlast", 64'(tlast_o), 64'd0);
      chk("rst_tdata", 64'(tdata_o), 64'd0);
      chk("rst_overflow", 64'(overflow_o), 64'd0);
      chk("rst_line_cnt", 64'(line_cnt_o), 64'd0);
      chk("tkeep", 64'(tkeep_o), 64'h3);
      rstn_i = 1'b1;
      ready_mode = 1;
      tick();

      // Lines before any vsync are discarded.
      base = beat_cnt;
      send_line(8, 0);
      send_line(12, 0);
      repeat (10) tick();
      chk("pre_vsync_beats", 64'(beat_cnt - base), 64'd0);

      // Basic frame: 0x11..0x88 -> 4 beats.
      send_vsync();
      line_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_line(8, 0);
      wait_drain("drain_basic");
      chk("line_cnt_basic", 64'(line_cnt_o), 64'(model_lines));

      // Odd byte count: trailing partial pixel dropped.
      send_line(5, 0);
      wait_drain("drain_odd");
      chk("line_cnt_odd", 64'(line_cnt_o), 64'(model_lines));

      // Back-pressure within FIFO capacity.
      ready_mode = 0;
      send_line(20, 1);
      chk("stall_tvalid", 64'(tvalid_o), 64'd1);
      chk("stall_head", 64'(tdata_o), exp_q[0].data);
      held = tdata_o;
      repeat (5) tick();
      chk("stall_stable", 64'(tdata_o), 64'(held));
      chk("stall_no_ovf", 64'(overflow_o), 64'd0);
      ready_mode = 1;
      wait_drain("drain_stall");

      // Overflow: 20 pixels into a 16-deep FIFO with the sink stalled.
      ready_mode = 0;
      send_line(40, 1);
      chk("ovf_set", 64'(overflow_o), 64'd1);
      send_line(8, 0);
      ready_mode = 1;
      wait_drain("drain_ovf");
      send_vsync();
      send_line(6, 0);
      wait_drain("drain_resync");
      chk("ovf_sticky", 64'(overflow_o), 64'd1);
      chk("line_cnt_resync", 64'(line_cnt_o), 64'(model_lines));

      // Randomized frames with random sink back-pressure.
      apply_reset();
      rstn_i = 1'b1;
      ready_mode = 2;
      tick();
      for (int f = 0; f < 5; f++) begin
         send_vsync();
         for (int l = 0; l < int'($urandom_range(1, 5)); l++) send_line(int'($urandom_range(0, 21)), 0);
         chk("rand_line_cnt", 64'(line_cnt_o), 64'(model_lines));
      end
      wait_drain("drain_rand");
      chk("rand_no_ovf", 64'(overflow_o), 64'd0);

      // Reset mid-line with beats waiting in the FIFO.
      ready_mode = 0;
      send_vsync();
      hsync_i = 1'b1;
      for (int i = 0; i < 11; i++) begin
         data_i = DW'($urandom);
         tick();
      end
      chk("pre_rst_tvalid", 64'(tvalid_o), 64'd1);
      rstn_i = 1'b0;
      tick();
      chk("mid_rst_tvalid", 64'(tvalid_o), 64'd0);
      chk("mid_rst_line_cnt", 64'(line_cnt_o), 64'd0);
      chk("mid_rst_tdata", 64'(tdata_o), 64'd0);
      exp_q.delete();
      model_active = 0;
      hsync_i = 1'b0;
      tick();
      rstn_i = 1'b1;
      ready_mode = 1;
      base = beat_cnt;
      repeat (20) tick();
      chk("post_rst_beats", 64'(beat_cnt - base), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dvp_axis_pack.md
Name: dvp_axis_pack

Overview:
- Parametrised successor to the single-byte DVP→AXIS bridge.
- Captures multi-byte pixels from a parallel DVP camera bus (e.g. 2-byte RGB565) and packs them into one AXIS beat per pixel.
- Marks start-of-frame on tuser and end-of-line on tlast.
- Absorbs sink back-pressure in an internal FIFO, with overflow detection and frame-level resync.
- Sits between the camera pins and the downstream video pipeline, in the pixel clock domain.

Parameters:
- DATA_WIDTH_P, 8, DVP data bus width in bits.
- BYTES_PER_PIXEL_P, 2, bus samples per pixel (≥1).
- FIFO_DEPTH_P, 16, output FIFO depth in words (power of 2, ≥4).
- LINE_CNT_W_P, 12, width of the line counter.

Ports:
- pclk_i  in  1  pixel clock; sole clock.
- rstn_i  in  1  reset; synchronous, active-low.
- vsync_i  in  1  frame sync; rising edge = new frame.
- hsync_i  in  1  line valid; high while pixel bytes are present.
- data_i  in  DATA_WIDTH_P  DVP sample.
- tdata_o  out  DATA_WIDTH_P*BYTES_PER_PIXEL_P  packed pixel.
- tkeep_o  out  DATA_WIDTH_P*BYTES_PER_PIXEL_P/8  all ones (constant).
- tuser_o  out  1  start of frame (first pixel of frame).
- tlast_o  out  1  last pixel of line.
- tvalid_o  out  1  beat valid.
- tready_i  in  1  sink ready.
- overflow_o  out  1  sticky; FIFO overflow occurred.
- line_cnt_o  out  LINE_CNT_W_P  lines completed in current frame.

Behaviour:
- Reset:
  - All registered outputs 0: tvalid_o, tuser_o, tlast_o, tdata_o, overflow_o, line_cnt_o.
  - FIFO emptied; FSM to IDLE.
  - A reset mid-line discards all partial and pending data.
- Input stage: vsync_i, hsync_i and data_i are registered once; all edge detection uses the registered copies and their one-cycle-delayed versions.
- FSM:
  - IDLE: discard all data; registered vsync rising edge → ACTIVE.
  - ACTIVE: pack and push. FIFO push attempted while full → RESYNC.
  - RESYNC: discard all data; vsync rising edge → ACTIVE.
- Frame start (vsync rising edge, in any state):
  - Arm sof flag.
  - Clear byte counter and pending word.
  - line_cnt_o ← 0.
- Packing (ACTIVE, registered hsync=1):
  - Byte counter counts 0..BYTES_PER_PIXEL_P-1; first sample goes to the MS byte.
  - On the final byte, the completed word moves into a one-entry pending register together with the sof flag; sof clears.
  - If pending is already occupied, the old pending word is pushed with last=0.
- Line end (registered hsync falling edge):
  - Pending word pushed with last=1; line_cnt_o increments (wraps at 2^LINE_CNT_W_P).
  - Partial pixel (byte counter ≠0) discarded; counter cleared.
  - Line with zero complete pixels: nothing pushed, no count.
- Simultaneous pixel completion and hsync fall are impossible, because hsync gates the data.
- FIFO:
  - Synchronous, first-word-fall-through; width = pixel + tuser + tlast.
  - tvalid_o = !empty. Pop on tvalid_o & tready_i.
  - Full is evaluated before the same-cycle pop: a push while full is rejected even if a pop occurs.
  - Output fields hold stable while tvalid_o=1 and tready_i=0.
- Overflow:
  - Rejected push sets overflow_o (sticky until reset) and enters RESYNC.
  - Words already in the FIFO still drain.
- Latency:
  - Non-last pixel: reaches the FIFO when the next pixel completes.
  - Last pixel: written 2 cycles after the hsync fall on the pins.
  - tvalid_o rises the cycle after the write.

Optional Feature:
- DVP_AXIS_PACK_BYTESWAP_EN defined: the first sample of each pixel goes to the LS byte of tdata_o (little-endian packing).
- Undefined: first sample goes to the MS byte.
- No other behaviour changes.

Decomposition:
- Package dvp_axis_pkg:
  - FSM state enum (IDLE, ACTIVE, RESYNC).
  - Sideband struct {tuser, tlast}.
  - Helper localparam for the packed word width.
- One sub-module: axis_sync_fifo (parametrised width/depth, FWFT, full/empty flags). It is reused by later pipeline stages.

Test Plan:
- Reset, then vsync pulse, then a line of 8 bytes 0x11..0x88 with tready=1 → 4 beats 0x1122, 0x3344, 0x5566, 0x7788; tuser on the first beat only; tlast on 0x7788; line_cnt_o=1.
- Line of 5 bytes → 2 beats; the 5th byte is dropped; tlast on the 2nd beat.
- tready=0 for a 10-pixel line, FIFO_DEPTH_P=16 → tvalid held, beat 0 stable, no overflow; release → 10 beats in order.
- tready=0 for 20 pixels → overflow_o=1 after the 17th pixel push attempt; first 16 beats drain; data ignored until the next vsync; the next frame starts with tuser=1.
- Lines before the first vsync after reset → no beats emitted.
- rstn_i low mid-line with 3 beats in the FIFO → tvalid_o=0 next cycle; line_cnt_o=0; no stale beats after reset.
